// File: rtl/segre_icache_refill.sv
// Instruction-cache refill engine.
// On a miss it requests one lane from memory, gathers the lane beat by beat
// (beat 0 = lowest address) and writes the full lane into the icache data
// array through its MMU write port in a single cycle.
//
// Handshakes:
//   - Memory request: mem_rd_req_o is held high with a stable mem_addr_o
//     until the first cycle mem_gnt_i is sampled high; that edge completes it.
//     mem_gnt_i has no meaning while no request is outstanding.
//   - Memory response: each edge in RECV with mem_rsp_valid_i high consumes
//     one beat. There is no back-pressure, so a beat is never refused.
//     Beats outside RECV, including one coincident with the grant, are dropped.
//   - Data-array write: mmu_wr_data_o is a one-cycle strobe. The array captures
//     mmu_addr_o/mmu_data_o at the edge ending that cycle. refill_done_o pulses
//     in the same cycle.
module segre_icache_refill #(
    parameter int WORD_SIZE = 32,
    parameter int LANE_SIZE = 128,
    parameter int BYTE_SIZE = 4,
    parameter int BEAT_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 miss_i,
    input  logic [WORD_SIZE-1:0] miss_addr_i,
    output logic                 busy_o,
    output logic                 mem_rd_req_o,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rsp_valid_i,
    input  logic [BEAT_SIZE-1:0] mem_rsp_data_i,
    output logic                 mmu_wr_data_o,
    output logic [WORD_SIZE-1:0] mmu_addr_o,
    output logic [LANE_SIZE-1:0] mmu_data_o,
    output logic                 refill_done_o
);

    localparam int NUM_BEATS = LANE_SIZE / BEAT_SIZE;
    localparam int CNT_W     = $clog2(NUM_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RECV  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [WORD_SIZE-1:0]  addr_q;
    logic [LANE_SIZE-1:0]  lane_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  beat_take;
    logic                  miss_take;

    // A miss is only accepted from IDLE; a beat is only accepted in RECV.
    assign miss_take = (state_q == IDLE) && miss_i;
    assign beat_take = (state_q == RECV) && mem_rsp_valid_i;

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: request until granted, collect all beats, write once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (miss_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (mem_rsp_valid_i && (cnt_q == LAST_BEAT)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lane-aligned address capture on an accepted miss.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            addr_q <= '0;
        end else if (miss_take) begin
            addr_q <= {miss_addr_i[WORD_SIZE-1:BYTE_SIZE], {BYTE_SIZE{1'b0}}};
        end
    end

    // Beat counter: cleared on a new miss, advanced per accepted beat and
    // allowed to wrap after the last one (it is not consulted in WRITE).
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            cnt_q <= '0;
        end else if (miss_take) begin
            cnt_q <= '0;
        end else if (beat_take) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Lane buffer: each accepted beat lands in its slot, lowest address first.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            lane_q <= '0;
        end else if (beat_take) begin
            lane_q[int'(cnt_q)*BEAT_SIZE +: BEAT_SIZE] <= mem_rsp_data_i;
        end
    end

    // Outputs come straight from registers or from a decode of the state.
    assign busy_o        = (state_q != IDLE);
    assign mem_rd_req_o  = (state_q == REQ);
    assign mmu_wr_data_o = (state_q == WRITE);
    assign refill_done_o = (state_q == WRITE);
    assign mem_addr_o    = addr_q;
    assign mmu_addr_o    = addr_q;
    assign mmu_data_o    = lane_q;

endmodule

// File: tb/tb_segre_icache_refill.sv
// Self-checking bench for segre_icache_refill: directed scenarios followed by
// randomized refills, compared against a lane-level reference model.
module tb_segre_icache_refill;

    localparam int W  = 32;
    localparam int L  = 128;
    localparam int BT = 32;
    localparam int NB = L / BT;

    typedef logic [L+W-1:0] cv_t;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rsn_i;
    always #5 clk_i = ~clk_i;

    logic          miss_i;
    logic [W-1:0]  miss_addr_i;
    logic          busy_o;
    logic          mem_rd_req_o;
    logic [W-1:0]  mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rsp_valid_i;
    logic [BT-1:0] mem_rsp_data_i;
    logic          mmu_wr_data_o;
    logic [W-1:0]  mmu_addr_o;
    logic [L-1:0]  mmu_data_o;
    logic          refill_done_o;

    segre_icache_refill #(
        .WORD_SIZE(W), .LANE_SIZE(L), .BYTE_SIZE(4), .BEAT_SIZE(BT)
    ) dut (
        .clk_i          (clk_i),
        .rsn_i          (rsn_i),
        .miss_i         (miss_i),
        .miss_addr_i    (miss_addr_i),
        .busy_o         (busy_o),
        .mem_rd_req_o   (mem_rd_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i (mem_rsp_data_i),
        .mmu_wr_data_o  (mmu_wr_data_o),
        .mmu_addr_o     (mmu_addr_o),
        .mmu_data_o     (mmu_data_o),
        .refill_done_o  (refill_done_o)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input cv_t got, input cv_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [BT-1:0] beats_v[NB];
    int            gaps_v[NB];
    bit            inject_miss;
    logic [L-1:0]  last_lane;   // what the lane buffer should hold now
    logic [W-1:0]  last_addr;   // what the address register should hold now
    logic [L+W-1:0] exp_q[$];   // {addr, lane} of every write we expect

    function automatic logic [L-1:0] build_lane();
        logic [L-1:0] lane;
        lane = '0;
        for (int k = 0; k < NB; k++) begin
            lane = lane | (L'(beats_v[k]) << (k * BT));
        end
        return lane;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_i) begin
        if (mmu_wr_data_o) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", cv_t'(1'b1), cv_t'(1'b0));
            end else begin
                cv_t e;
                e = exp_q.pop_front();
                check_val("wr_addr", cv_t'(mmu_addr_o), cv_t'(e[L+W-1:L]));
                check_val("wr_lane", cv_t'(mmu_data_o), cv_t'(e[L-1:0]));
                check_val("wr_done", cv_t'(refill_done_o), cv_t'(1'b1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, cv_t'(busy_o), cv_t'(1'b0));
        check_val({tag, "_req"},  cv_t'(mem_rd_req_o), cv_t'(1'b0));
        check_val({tag, "_wr"},   cv_t'(mmu_wr_data_o), cv_t'(1'b0));
        check_val({tag, "_done"}, cv_t'(refill_done_o), cv_t'(1'b0));
        check_val({tag, "_lane"}, cv_t'(mmu_data_o), cv_t'(last_lane));
        check_val({tag, "_addr"}, cv_t'(mem_addr_o), cv_t'(last_addr));
    endtask

    // One complete refill: gw cycles without grant, then gaps_v[k] idle
    // response cycles before beat k.
    task automatic do_refill(input logic [W-1:0] addr, input int gw);
        logic [W-1:0] la;
        logic [L-1:0] lane;
        la   = {addr[W-1:4], 4'h0};
        lane = build_lane();
        exp_q.push_back({la, lane});
        miss_i = 1'b1;
        miss_addr_i = addr;
        step();
        miss_i = 1'b0;
        miss_addr_i = $urandom;
        for (int c = 0; c <= gw; c++) begin
            check_val("req_high", cv_t'(mem_rd_req_o), cv_t'(1'b1));
            check_val("req_addr", cv_t'(mem_addr_o), cv_t'(la));
            check_val("req_busy", cv_t'(busy_o), cv_t'(1'b1));
            check_val("req_nowr", cv_t'(mmu_wr_data_o), cv_t'(1'b0));
            mem_gnt_i = (c == gw);
            mem_rsp_valid_i = 1'($urandom_range(0, 1));
            mem_rsp_data_i = $urandom;
            step();
        end
        mem_gnt_i = 1'b0;
        for (int k = 0; k < NB; k++) begin
            for (int g = 0; g < gaps_v[k]; g++) begin
                mem_rsp_valid_i = 1'b0;
                mem_rsp_data_i = $urandom;
                mem_gnt_i = 1'($urandom_range(0, 1));
                if (inject_miss) begin
                    miss_i = 1'b1;
                    miss_addr_i = 32'h0000_2000;
                end
                check_val("recv_busy", cv_t'(busy_o), cv_t'(1'b1));
                check_val("recv_noreq", cv_t'(mem_rd_req_o), cv_t'(1'b0));
                check_val("recv_nowr", cv_t'(mmu_wr_data_o), cv_t'(1'b0));
                step();
            end
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i = beats_v[k];
            check_val("beat_busy", cv_t'(busy_o), cv_t'(1'b1));
            check_val("beat_noreq", cv_t'(mem_rd_req_o), cv_t'(1'b0));
            check_val("beat_nowr", cv_t'(mmu_wr_data_o), cv_t'(1'b0));
            step();
        end
        mem_rsp_valid_i = 1'b0;
        mem_gnt_i = 1'b0;
        miss_i = 1'b0;
        check_val("write_strobe", cv_t'(mmu_wr_data_o), cv_t'(1'b1));
        check_val("write_done", cv_t'(refill_done_o), cv_t'(1'b1));
        check_val("write_addr", cv_t'(mmu_addr_o), cv_t'(la));
        check_val("write_lane", cv_t'(mmu_data_o), cv_t'(lane));
        check_val("write_busy", cv_t'(busy_o), cv_t'(1'b1));
        last_lane = lane;
        last_addr = la;
        step();
        check_idle("after_write");
    endtask

    task automatic rand_beats();
        for (int k = 0; k < NB; k++) beats_v[k] = $urandom;
    endtask

    task automatic no_gaps();
        for (int k = 0; k < NB; k++) gaps_v[k] = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rsn_i = 1'b0;
        miss_i = 1'b0;
        miss_addr_i = '0;
        mem_gnt_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i = '0;
        inject_miss = 1'b0;
        last_lane = '0;
        last_addr = '0;
        #12;
        check_idle("reset");
        check_val("reset_mmu_addr", cv_t'(mmu_addr_o), cv_t'(32'h0));
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        step();

        // Basic refill with immediate grant and back-to-back beats.
        beats_v[0] = 32'h1111_1111;
        beats_v[1] = 32'h2222_2222;
        beats_v[2] = 32'h3333_3333;
        beats_v[3] = 32'h4444_4444;
        no_gaps();
        do_refill(32'h0000_1234, 0);

        // Grant stall of five cycles.
        rand_beats();
        do_refill(32'h8000_0ABC, 5);

        // Valid pattern 1,0,0,1,1,0,1.
        rand_beats();
        gaps_v[0] = 0; gaps_v[1] = 2; gaps_v[2] = 0; gaps_v[3] = 1;
        do_refill(32'h0000_4FFF, 0);

        // Miss pulsed while receiving is ignored; the next miss is taken.
        rand_beats();
        for (int k = 0; k < NB; k++) gaps_v[k] = 1;
        inject_miss = 1'b1;
        do_refill(32'h0000_5678, 1);
        inject_miss = 1'b0;
        rand_beats();
        no_gaps();
        do_refill(32'h0000_2000, 0);

        // Spurious response while idle must not touch the lane buffer.
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i = 32'hDEAD_BEEF;
            step();
            check_idle("spurious");
        end
        mem_rsp_valid_i = 1'b0;
        rand_beats();
        gaps_v[0] = 1; gaps_v[1] = 0; gaps_v[2] = 0; gaps_v[3] = 0;
        do_refill(32'h0001_0008, 2);

        // Reset in the middle of RECV after two beats.
        rand_beats();
        miss_i = 1'b1;
        miss_addr_i = 32'h0000_3004;
        step();
        miss_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i = beats_v[k];
            step();
        end
        mem_rsp_valid_i = 1'b0;
        check_val("pre_reset_busy", cv_t'(busy_o), cv_t'(1'b1));
        #2;
        rsn_i = 1'b0;
        #1;
        last_lane = '0;
        last_addr = '0;
        check_idle("async_reset");
        check_val("async_reset_mmu_addr", cv_t'(mmu_addr_o), cv_t'(32'h0));
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i = $urandom;
            step();
            check_idle("stray_beat");
        end
        mem_rsp_valid_i = 1'b0;

        // Randomized refills.
        for (int n = 0; n < 40; n++) begin
            rand_beats();
            for (int k = 0; k < NB; k++) gaps_v[k] = $urandom_range(0, 2);
            inject_miss = 1'($urandom_range(0, 1));
            do_refill($urandom, $urandom_range(0, 3));
            inject_miss = 1'b0;
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                step();
                check_idle("rand_idle");
            end
        end

        step();
        step();
        check_val("exp_q_empty", cv_t'(exp_q.size()), cv_t'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
